// File: rtl/uart_tx_serializer_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the UART transmit serializer.
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - clog2() helper used to size the baud counter and the bit index
// Optional feature macro used by the importing files: UART_TX_PARITY_EN
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Width needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer_if
// Bundles the register-file side of the UART transmitter.
//   p_data      parallel byte to send (sampled on frame start)
//   data_valid  level request from the control register
//   tx_out      serial line, idle high
//   busy        frame in progress
//   tx_done     one-cycle pulse at frame completion
// Modports: master = register file side, slave = serializer side.
// Optional feature macro (used by the serializer): UART_TX_PARITY_EN
// -----------------------------------------------------------------------------
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  tx_out;
    logic                  busy;
    logic                  tx_done;

    modport master (
        output p_data,
        output data_valid,
        input  tx_out,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  p_data,
        input  data_valid,
        output tx_out,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_serializer_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_tx_baud_cnt
// Baud counter for the UART serializer: counts 0..CLKS_PER_BIT-1 and flags
// the last count of each serial bit.
// Ports:
//   clk        system clock
//   rst        asynchronous, active-low reset
//   clr_i      state-entry strobe from the FSM; next count is 0
//   bit_end_o  high during the last clk of the current serial bit
// Optional feature macro of the enclosing design: UART_TX_PARITY_EN (unused here)
// -----------------------------------------------------------------------------
module uart_tx_baud_cnt
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic bit_end_o
);
    localparam int               CNT_W    = clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
// UART transmit engine. On a rising edge of data_valid while idle it captures
// p_data and sends start bit, DATA_WIDTH data bits LSB first, an optional
// parity bit and a stop bit, each CLKS_PER_BIT clks long.
// Ports:
//   clk   system clock
//   rst   asynchronous, active-low reset
//   bus   uart_tx_serializer_if.slave (p_data, data_valid in; tx_out, busy,
//         tx_done out)
// Optional feature macro: UART_TX_PARITY_EN -- inserts a PARITY state after
// DATA and adds parameter PAR_ODD (0 = even, 1 = odd parity).
// -----------------------------------------------------------------------------
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PAR_ODD      = 1'b0
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_serializer_if.slave   bus
);
    localparam int               IDX_W    = clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    logic [2:0]            state_q,  state_d;
    logic [DATA_WIDTH-1:0] shift_q,  shift_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic                  valid_q;
    logic                  tx_q,     tx_d;
    logic                  busy_q,   busy_d;
    logic                  done_q,   done_d;
`ifdef UART_TX_PARITY_EN
    logic                  par_q,    par_d;
`endif

    logic start;
    logic bit_end;
    logic cnt_clr;

    // Counter is held at zero while idle and restarts on every state change,
    // so each non-idle state lasts exactly CLKS_PER_BIT clks.
    assign cnt_clr = (state_d != state_q) || (state_q == IDLE);

    uart_tx_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .bit_end_o (bit_end)
    );

    // Edge-qualified start: a held level sends one frame, edges while busy drop.
    assign start = bus.data_valid && !valid_q && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    shift_d = bus.p_data;
                    idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^bus.p_data) ^ PAR_ODD;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is decoded from the next state so tx_out can be registered
        // without adding a cycle of latency.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && bit_end;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            valid_q <= bus.data_valid;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.tx_out  = tx_q;
    assign bus.busy    = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit engine directly downstream of the UART register file. Takes the parallel byte (tx_p_data) and the control-register valid level (uart_tx_data_valid) from that block. Emits an asynchronous serial frame on tx_out: start bit, data bits LSB first, optional parity, stop bit. Returns busy and a done pulse, which the register file samples into its status register.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
p_data  input  DATA_WIDTH  parallel byte; sampled only on frame start
data_valid  input  1  level request from control reg bit 0; start is edge-qualified
tx_out  output  1  serial line; idle high
busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async assert, sync release): tx_out=1, busy=0, tx_done=0, state=IDLE, valid_q=0, shift reg=0, counters=0. Mid-frame reset aborts the frame immediately; tx_out returns high with no partial stop bit.
- Start condition: start = data_valid & ~valid_q & (state==IDLE), where valid_q is data_valid delayed one clk.
  - A level held high sends exactly one frame. A new frame needs data_valid to fall and rise again.
  - Rising edge while busy=1: dropped, not queued.
  - Because valid_q resets to 0, data_valid already high out of reset sends one frame.
- On start, capture p_data into the shift register, compute parity if enabled, and enter START.
- Latency: tx_out goes low in the clk after start is sampled; busy rises in the same clk.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Each non-IDLE state lasts exactly CLKS_PER_BIT cycles, counted by the baud counter (0..CLKS_PER_BIT-1).
  - The baud counter clears on every state entry.
  - DATA uses a bit index 0..DATA_WIDTH-1. tx_out = shift[0], and the shift register shifts right at each bit end.
  - DATA exits to PARITY or STOP after bit DATA_WIDTH-1.
- tx_out values: START drives 0, DATA drives the data bit, PARITY drives the parity bit, STOP drives 1, IDLE drives 1. tx_out is registered (glitch-free).
- busy: 1 for the whole frame, (DATA_WIDTH+2[+1])*CLKS_PER_BIT cycles. It drops in the clk after the last STOP cycle.
- tx_done: 1-cycle pulse in that same clk, coincident with the busy fall and the return to IDLE.
- Back-to-back frames: a start edge is accepted in the same cycle tx_done is high, since the state is IDLE then.
- p_data changes during a frame have no effect on the frame in progress.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - Adds parameter PAR_ODD (default 0).
  - PARITY state is inserted after DATA.
  - Parity bit = ^data (even) or ~^data (odd), computed from the captured byte.
  - Frame length becomes DATA_WIDTH+3 bits.
- When undefined: no parity logic and no PARITY state; the frame is DATA_WIDTH+2 bits.

Decomposition:
- Package uart_tx_pkg holds:
  - State encoding localparams: IDLE, START, DATA, PARITY, STOP (3-bit).
  - A clog2 function used for the baud counter and bit index widths.
- One natural sub-module, uart_tx_baud_cnt:
  - Counts 0..CLKS_PER_BIT-1 and asserts bit_end on the last count.
  - Clears on the FSM's state-entry strobe.
  - Resets with rst.

Test Plan (CLKS_PER_BIT=4, DATA_WIDTH=8):
1. Reset: assert rst=0 mid-idle -> tx_out=1, busy=0, tx_done=0 immediately.
2. No parity: p_data=0xA5, data_valid 0->1 -> tx_out 0,1,0,1,0,0,1,0,1,1, each for 4 clks. busy high for 40 clks; a single tx_done pulse as busy falls.
3. Hold data_valid=1 for 200 clks after a start with p_data=0x3C -> exactly one frame and one tx_done.
4. Second rising edge of data_valid at clk 10 of a frame -> ignored; only the first frame appears, and tx_out stays 1 afterwards.
5. UART_TX_PARITY_EN:
   - PAR_ODD=0, 0xA5 -> parity bit 0, busy 44 clks.
   - PAR_ODD=0, 0x07 -> parity bit 1.
   - PAR_ODD=1, 0xA5 -> parity bit 1.
6. Reset pulse during data bit 3 of a 0xFF frame -> tx_out=1 and busy=0 at once. The next rising edge sends a complete, correct frame.
